// File: rtl/mem_op_seq.sv
// mem_op_seq: operand-fetch / write-back sequencer for the 8x32 RAM and the
// AND/OR operator unit. A start request walks the FSM through two operand
// reads, one operator cycle, one result write-back and a done pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; latches addresses and mode when it arrives
// RD_A   | mem_addr = a_q, operand A captured from mem_rdata at the edge
// RD_B   | mem_addr = b_q, operand B captured from mem_rdata at the edge
// OPER   | operands and mode stable; operator registers op_c at the edge
// WR     | mem_addr = c_q, mem_wdata = op_c, mem_wmode = 1 for one cycle
// DONE   | done = 1, op_count advances at the edge, back to IDLE
module mem_op_seq #(
  parameter int AW = 3,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          or_mode,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  input  logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] op_count,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wmode,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          op_mode,
  input  logic [DW-1:0] op_c
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_OPER = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t        state_q;
  logic [AW-1:0] a_q;
  logic [AW-1:0] b_q;
  logic [AW-1:0] c_q;
  logic          mode_q;
  logic [AW-1:0] addr_q;
  logic          wmode_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [DW-1:0] op_a_q;
  logic [DW-1:0] op_b_q;

  // Completed-operation counter wraps naturally at 2**CW.
  always_comb begin
    count_d = count_q + CW'(1);
  end

  // Sequencer FSM; every visible control output is a register set on the
  // transition into the state that needs it, so reset clears them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wmode_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_addr;
            b_q     <= b_addr;
            c_q     <= c_addr;
            mode_q  <= or_mode;
            addr_q  <= a_addr;
            busy_q  <= 1'b1;
            state_q <= S_RD_A;
          end
        end
        S_RD_A: begin
          op_a_q  <= mem_rdata;
          addr_q  <= b_q;
          state_q <= S_RD_B;
        end
        S_RD_B: begin
          op_b_q  <= mem_rdata;
          addr_q  <= '0;
          state_q <= S_OPER;
        end
        S_OPER: begin
          addr_q  <= c_q;
          wmode_q <= 1'b1;
          state_q <= S_WR;
        end
        S_WR: begin
          addr_q  <= '0;
          wmode_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          count_q <= count_d;
          state_q <= S_IDLE;
        end
        default: begin
          addr_q  <= '0;
          wmode_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // op_c only becomes valid at the edge that enters WR, so the write data is
  // gated from the operator result by the registered write enable.
  always_comb begin
    mem_wdata = wmode_q ? op_c : '0;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign op_count  = count_q;
  assign mem_addr  = addr_q;
  assign mem_wmode = wmode_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_mode   = mode_q;

endmodule

// File: tb/tb_mem_op_seq.sv
// Directed bench for mem_op_seq with a behavioural 8x32 RAM and a registered
// AND/OR operator attached.
module tb_mem_op_seq;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          or_mode;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic          busy, done, mem_wmode, op_mode;
  logic [CW-1:0] op_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, op_a, op_b;
  logic [DW-1:0] op_c;

  logic [DW-1:0] ram [8];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  int total = 0;
  int bad = 0;

  logic [5:0]    tr_done, tr_busy, tr_wm;
  logic [AW-1:0] tr_addr [6];
  logic [DW-1:0] tr_wd3;

  always #5 clk = ~clk;

  mem_op_seq #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .or_mode(or_mode),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .busy(busy), .done(done), .op_count(op_count),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmode(mem_wmode),
    .mem_rdata(mem_rdata), .op_a(op_a), .op_b(op_b), .op_mode(op_mode),
    .op_c(op_c)
  );

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_wmode) ram[mem_addr] <= mem_wdata;
    else if (pl_we) ram[pl_addr] <= pl_data;
  end

  always @(posedge clk) op_c <= op_mode ? (op_a | op_b) : (op_a & op_b);

  initial begin
    #300000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic record(input int i);
    tr_done[i] = done;
    tr_busy[i] = busy;
    tr_wm[i]   = mem_wmode;
    tr_addr[i] = mem_addr;
    if (i == 3) tr_wd3 = mem_wdata;
  endtask

  // One start pulse, then sample after each of edges E0..E5.
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic m);
    @(negedge clk);
    a_addr = a; b_addr = b; c_addr = c; or_mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    record(0);
    for (int i = 1; i < 6; i++) begin
      tick();
      record(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; or_mode = 1'b0;
    a_addr = '0; b_addr = '0; c_addr = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (mem_wmode !== 1'b0) begin bad++; $display("FAIL reset_wmode got=%b exp=0", mem_wmode); end
    total++; if (mem_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    total++; if (op_count !== 8'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", op_count); end
    total++; if ({op_a, op_b, op_mode} !== 65'h0) begin bad++; $display("FAIL reset_operands got=%h/%h/%b exp=0", op_a, op_b, op_mode); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_and();
    preload(3'd1, 32'hF0F0_00FF);
    preload(3'd2, 32'h0FF0_0F0F);
    issue(3'd1, 3'd2, 3'd5, 1'b0);
    total++; if (tr_done !== 6'b010000) begin bad++; $display("FAIL and_done_timing got=%b exp=010000", tr_done); end
    total++; if (tr_busy !== 6'b011111) begin bad++; $display("FAIL and_busy_timing got=%b exp=011111", tr_busy); end
    total++; if (tr_wm !== 6'b001000) begin bad++; $display("FAIL and_wmode_timing got=%b exp=001000", tr_wm); end
    total++; if (tr_addr[0] !== 3'd1) begin bad++; $display("FAIL and_addr_rda got=%h exp=1", tr_addr[0]); end
    total++; if (tr_addr[1] !== 3'd2) begin bad++; $display("FAIL and_addr_rdb got=%h exp=2", tr_addr[1]); end
    total++; if (tr_addr[3] !== 3'd5) begin bad++; $display("FAIL and_addr_wr got=%h exp=5", tr_addr[3]); end
    total++; if (tr_wd3 !== 32'h00F0_000F) begin bad++; $display("FAIL and_wdata got=%h exp=00f0000f", tr_wd3); end
    total++; if (ram[5] !== 32'h00F0_000F) begin bad++; $display("FAIL and_ram5 got=%h exp=00f0000f", ram[5]); end
    total++; if (op_a !== 32'hF0F0_00FF) begin bad++; $display("FAIL and_op_a got=%h exp=f0f000ff", op_a); end
    total++; if (op_b !== 32'h0FF0_0F0F) begin bad++; $display("FAIL and_op_b got=%h exp=0ff00f0f", op_b); end
    total++; if (op_count !== 8'd1) begin bad++; $display("FAIL and_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_or_alias();
    issue(3'd1, 3'd2, 3'd1, 1'b1);
    total++; if (op_mode !== 1'b1) begin bad++; $display("FAIL or_mode got=%b exp=1", op_mode); end
    total++; if (ram[1] !== 32'hFFF0_0FFF) begin bad++; $display("FAIL or_ram1 got=%h exp=fff00fff", ram[1]); end
    total++; if (ram[2] !== 32'h0FF0_0F0F) begin bad++; $display("FAIL or_ram2_kept got=%h exp=0ff00f0f", ram[2]); end
    issue(3'd1, 3'd1, 3'd3, 1'b0);
    total++; if (ram[3] !== 32'hFFF0_0FFF) begin bad++; $display("FAIL alias_ram3 got=%h exp=fff00fff", ram[3]); end
    total++; if (op_count !== 8'd3) begin bad++; $display("FAIL alias_count got=%0d exp=3", op_count); end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    ndone = 0;
    preload(3'd6, 32'h0);
    preload(3'd7, 32'hDEAD_BEEF);
    @(negedge clk);
    a_addr = 3'd2; b_addr = 3'd1; c_addr = 3'd6; or_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    a_addr = 3'd0; b_addr = 3'd0; c_addr = 3'd7; or_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL busy_ignore_dones got=%0d exp=1", ndone); end
    total++; if (ram[6] !== 32'h0FF0_0F0F) begin bad++; $display("FAIL busy_ignore_ram6 got=%h exp=0ff00f0f", ram[6]); end
    total++; if (ram[7] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL busy_ignore_ram7 got=%h exp=deadbeef", ram[7]); end
    total++; if (op_mode !== 1'b0) begin bad++; $display("FAIL busy_ignore_mode got=%b exp=0", op_mode); end
    total++; if (op_count !== 8'd4) begin bad++; $display("FAIL busy_ignore_count got=%0d exp=4", op_count); end
  endtask

  task automatic test_held_start();
    logic [17:0] dv;
    dv = '0;
    @(negedge clk);
    a_addr = 3'd1; b_addr = 3'd2; c_addr = 3'd4; or_mode = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      dv[i] = done;
    end
    start = 1'b0;
    for (int i = 12; i < 18; i++) begin
      tick();
      dv[i] = done;
    end
    total++; if (dv !== 18'h00410) begin bad++; $display("FAIL held_done_pattern got=%b exp=%b", dv, 18'h00410); end
    total++; if (ram[4] !== 32'h0FF0_0F0F) begin bad++; $display("FAIL held_ram4 got=%h exp=0ff00f0f", ram[4]); end
    total++; if (op_count !== 8'd6) begin bad++; $display("FAIL held_count got=%0d exp=6", op_count); end
  endtask

  task automatic test_reset_mid();
    preload(3'd0, 32'hCAFE_F00D);
    @(negedge clk);
    a_addr = 3'd1; b_addr = 3'd2; c_addr = 3'd0; or_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (mem_wmode !== 1'b0) begin bad++; $display("FAIL rstmid_wmode got=%b exp=0", mem_wmode); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", op_count); end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    total++; if (ram[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rstmid_ram0 got=%h exp=cafef00d", ram[0]); end
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    total++; if (mem_wmode !== 1'b1) begin bad++; $display("FAIL rstwr_pre_wmode got=%b exp=1", mem_wmode); end
    #1 rst = 1'b0;
    #1;
    total++; if (mem_wmode !== 1'b0) begin bad++; $display("FAIL rstwr_wmode got=%b exp=0", mem_wmode); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rstwr_wdata got=%h exp=0", mem_wdata); end
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    total++; if (ram[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rstwr_ram0 got=%h exp=cafef00d", ram[0]); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL rstwr_count got=%0d exp=0", op_count); end
  endtask

  task automatic test_wrap();
    int missed;
    missed = 0;
    for (int n = 1; n <= 256; n++) begin
      issue(3'd1, 3'd2, 3'd7, 1'b0);
      if (tr_done !== 6'b010000) missed++;
      if (n == 255) begin
        total++; if (op_count !== 8'd255) begin bad++; $display("FAIL wrap_count255 got=%0d exp=255", op_count); end
      end
    end
    total++; if (missed !== 0) begin bad++; $display("FAIL wrap_done_pulses got=%0d_missed exp=0_missed", missed); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL wrap_count0 got=%0d exp=0", op_count); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or_alias();
    test_busy_ignore();
    test_held_start();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
